// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises whole packets from NUM_REQ requesters onto a
// single edge-detected TX buffer write port, with inter-word gaps and a stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BIT_PER_WORD = 7,
    parameter int GAP_CYCLES   = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*(BIT_PER_WORD+1)-1:0] req_data,
    input  logic [NUM_REQ-1:0]                  req_last,
    output logic [NUM_REQ-1:0]                  req_ack,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [BIT_PER_WORD:0]               tx_data,
    output logic                                tx_strobe,
    input  logic                                tx_busy,
    output logic                                abort,
    output logic                                active
);

    localparam int WORD_W = BIT_PER_WORD + 1;
    localparam int IW     = $clog2(NUM_REQ);
    localparam int SW     = $clog2(TIMEOUT + 1);
    localparam int GW     = 4;
    localparam logic [NUM_REQ-1:0] ONE_HOT     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]      STALL_LIMIT = SW'(TIMEOUT - 1);
    localparam logic [GW-1:0]      GAP_LOAD    = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PUSH   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [IW-1:0]       r_gidx;
    logic [IW-1:0]       w_gidx_nxt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [WORD_W-1:0]   r_data;
    logic [WORD_W-1:0]   w_data_nxt;
    logic                r_strobe;
    logic                w_strobe_nxt;
    logic                r_abort;
    logic                w_abort_nxt;
    logic                r_active;
    logic                w_active_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic [SW-1:0]       r_stall;
    logic [SW-1:0]       w_stall_nxt;
    logic [GW-1:0]       r_gap;
    logic [GW-1:0]       w_gap_nxt;
    logic [IW-1:0]       r_last_owner;
    logic [IW-1:0]       w_last_owner_nxt;

    logic [WORD_W-1:0]   w_words [NUM_REQ];
    logic [IW-1:0]       w_rr_idx;
    logic                w_accept;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_words[gi] = req_data[gi*WORD_W +: WORD_W];
    end

    // Only the owner's request matters; the buffer being full blocks any sampling.
    assign w_accept = req[r_gidx] & ~tx_busy;

    // Round-robin search starting just after the previous owner, wrapping around.
    always_comb begin : rr_search
        int   v_idx;
        logic v_found;
        v_idx    = 0;
        v_found  = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx    = (int'(r_last_owner) + k) % NUM_REQ;
            w_rr_idx = (req[IW'(v_idx)] && !v_found) ? IW'(v_idx) : w_rr_idx;
            v_found  = v_found | req[IW'(v_idx)];
        end
    end

    // Next-state and next-output decode; acceptance wins over the timeout abort.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_gidx_nxt       = r_gidx;
        w_ack_nxt        = '0;
        w_data_nxt       = r_data;
        w_strobe_nxt     = 1'b0;
        w_abort_nxt      = 1'b0;
        w_active_nxt     = r_active;
        w_last_nxt       = r_last;
        w_stall_nxt      = r_stall;
        w_gap_nxt        = r_gap;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt  = S_PUSH;
                    w_grant_nxt  = ONE_HOT << w_rr_idx;
                    w_gidx_nxt   = w_rr_idx;
                    w_active_nxt = 1'b1;
                    w_stall_nxt  = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PUSH: begin
                if (w_accept) begin
                    w_state_nxt  = S_SETTLE;
                    w_strobe_nxt = 1'b1;
                    w_data_nxt   = w_words[r_gidx];
                    w_ack_nxt    = r_grant;
                    w_last_nxt   = req_last[r_gidx];
                    w_stall_nxt  = '0;
                    w_gap_nxt    = GAP_LOAD;
                end else if (r_stall == STALL_LIMIT) begin
                    w_state_nxt      = S_IDLE;
                    w_abort_nxt      = 1'b1;
                    w_grant_nxt      = '0;
                    w_active_nxt     = 1'b0;
                    w_last_owner_nxt = r_gidx;
                    w_stall_nxt      = '0;
                end else begin
                    w_stall_nxt = r_stall + SW'(1);
                end
            end
            S_SETTLE: begin
                if (r_gap == '0) begin
                    if (r_last) begin
                        w_state_nxt      = S_IDLE;
                        w_grant_nxt      = '0;
                        w_active_nxt     = 1'b0;
                        w_last_owner_nxt = r_gidx;
                    end else begin
                        w_state_nxt = S_PUSH;
                    end
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_grant_nxt  = '0;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, counter and ownership registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_gidx       <= '0;
            r_ack        <= '0;
            r_data       <= '0;
            r_strobe     <= 1'b0;
            r_abort      <= 1'b0;
            r_active     <= 1'b0;
            r_last       <= 1'b0;
            r_stall      <= '0;
            r_gap        <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
        end else begin
            r_grant      <= w_grant_nxt;
            r_gidx       <= w_gidx_nxt;
            r_ack        <= w_ack_nxt;
            r_data       <= w_data_nxt;
            r_strobe     <= w_strobe_nxt;
            r_abort      <= w_abort_nxt;
            r_active     <= w_active_nxt;
            r_last       <= w_last_nxt;
            r_stall      <= w_stall_nxt;
            r_gap        <= w_gap_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    assign grant     = r_grant;
    assign req_ack   = r_ack;
    assign tx_data   = r_data;
    assign tx_strobe = r_strobe;
    assign abort     = r_abort;
    assign active    = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all outputs compared
// every cycle against a procedural packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int BPW = 7;
    localparam int W   = BPW + 1;
    localparam int GAP = 3;
    localparam int TO  = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic            tx_busy = 1'b0;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic [W-1:0]    tx_data;
    logic            tx_strobe;
    logic            abort;
    logic            active;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .BIT_PER_WORD(BPW), .GAP_CYCLES(GAP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .grant(grant), .tx_data(tx_data), .tx_strobe(tx_strobe),
        .tx_busy(tx_busy), .abort(abort), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- requester agent ----------------
    logic [7:0]    pw [NR][8];
    int            plen [NR];
    int            ppos [NR];
    int            seen_seq [NR];
    int            ld_seq [NR];
    int            ld_len [NR];
    logic [7:0]    ld_base [NR];
    logic [NR-1:0] hold = '0;
    logic [NR-1:0] prev_grant = '0;
    bit            auto_mode = 1'b0;
    bit            rand_mode = 1'b0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            plen[i] = 0; ppos[i] = 0; seen_seq[i] = 0; ld_seq[i] = 0; ld_len[i] = 0; ld_base[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        logic [NR-1:0]   r_n;
        logic [NR-1:0]   l_n;
        logic [NR*W-1:0] d_n;
        #1;
        r_n = '0; l_n = '0; d_n = '0;
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                plen[i] = 0; ppos[i] = 0;
            end else begin
                if (req_ack[i]) ppos[i]++;
                if (abort && prev_grant[i]) ppos[i] = plen[i];
            end
            if (ld_seq[i] != seen_seq[i]) begin
                seen_seq[i] = ld_seq[i];
                plen[i] = ld_len[i]; ppos[i] = 0;
                for (int k = 0; k < 8; k++) pw[i][k] = ld_base[i] + 8'(k);
            end else if (ppos[i] >= plen[i] && !rst) begin
                if (auto_mode) begin
                    plen[i] = 1; ppos[i] = 0; pw[i][0] = 8'(160 + i);
                end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                    plen[i] = $urandom_range(1, 4); ppos[i] = 0;
                    for (int k = 0; k < 8; k++) pw[i][k] = 8'($urandom);
                end
            end
            r_n[i] = (ppos[i] < plen[i]) && !hold[i];
            d_n[i*W +: W] = (ppos[i] < plen[i]) ? pw[i][ppos[i]] : 8'($urandom);
            l_n[i] = (ppos[i] < plen[i]) ? (ppos[i] == plen[i] - 1) : 1'($urandom);
        end
        prev_grant = grant;
        req = r_n; req_last = l_n; req_data = d_n;
    end

    // ---------------- reference model (packet timeline) ----------------
    logic [NR-1:0] e_grant = '0;
    logic [NR-1:0] e_ack = '0;
    logic [W-1:0]  e_data = '0;
    logic          e_strobe = 1'b0;
    logic          e_abort = 1'b0;
    logic          e_active = 1'b0;
    int            m_last_owner = NR - 1;
    bit            m_valid = 1'b0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int lo);
        for (int k = 1; k <= NR; k++) begin
            if (r[(lo + k) % NR]) return (lo + k) % NR;
        end
        return 0;
    endfunction

    task automatic m_tick(output bit r);
        @(posedge clk);
        e_ack = '0; e_strobe = 1'b0; e_abort = 1'b0;
        r = rst;
        if (rst) begin
            e_grant = '0; e_active = 1'b0; e_data = '0; m_last_owner = NR - 1; m_valid = 1'b1;
        end
    endtask

    initial begin
        bit r;
        int own;
        int stalls;
        bit fin;
        bit lastw;
        forever begin
            m_tick(r);
            if (r || req == '0) continue;
            own = rr_pick(req, m_last_owner);
            e_grant = 4'b0001 << own; e_active = 1'b1;
            stalls = 0; fin = 1'b0;
            while (!fin) begin
                m_tick(r);
                if (r) break;
                if (req[own] && !tx_busy) begin
                    e_strobe = 1'b1; e_ack = 4'b0001 << own;
                    e_data = 8'(req_data >> (own * W)); lastw = req_last[own]; stalls = 0;
                    for (int k = 0; k <= GAP; k++) begin
                        m_tick(r);
                        if (r) break;
                    end
                    if (r) break;
                    if (lastw) begin
                        e_grant = '0; e_active = 1'b0; m_last_owner = own; fin = 1'b1;
                    end
                end else begin
                    stalls++;
                    if (stalls == TO) begin
                        e_abort = 1'b1; e_grant = '0; e_active = 1'b0; m_last_owner = own; fin = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_eq("grant", grant, e_grant);
            check_eq("req_ack", req_ack, e_ack);
            check_eq("tx_data", tx_data, e_data);
            check_eq("tx_strobe", tx_strobe, e_strobe);
            check_eq("abort", abort, e_abort);
            check_eq("active", active, e_active);
        end
    end

    // ---------------- directed scenarios and random phase ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int i, input int n, input logic [7:0] b);
        ld_len[i] = n; ld_base[i] = b; ld_seq[i] = ld_seq[i] + 1;
    endtask

    task automatic wait_quiet(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            cyc();
            if (!active && req == '0) begin ok = 1'b1; break; end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int            n_rec;
        int            rt [8];
        logic [7:0]    rd [8];
        logic [NR-1:0] rg [8];
        int            n_abort;
        logic [NR-1:0] g_at;
        logic [NR-1:0] next_g;
        logic [NR-1:0] prevg;
        bit            seen;
        int            n_str;

        // Reset, then two requesters at once: requester 0 wins, 2 follows.
        cyc(); cyc();
        rst = 1'b0;
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_active", active, 1'b0);
        check_eq("rst_strobe", tx_strobe, 1'b0);
        check_eq("rst_data", tx_data, 8'h00);
        load(0, 1, 8'h11); load(2, 1, 8'h33);
        cyc();
        cyc();
        check_eq("s1_grant", grant, 4'b0001);
        check_eq("s1_no_strobe_yet", tx_strobe, 1'b0);
        cyc();
        check_eq("s1_strobe_n2", tx_strobe, 1'b1);
        check_eq("s1_ack", req_ack, 4'b0001);
        check_eq("s1_data", tx_data, 8'h11);
        for (int t = 0; t < 30; t++) begin
            cyc();
            if (grant != '0 && grant != 4'b0001) break;
        end
        check_eq("s1_next_grant", grant, 4'b0100);
        wait_quiet("s1_quiet");

        // Three-word packet from requester 1 while requester 2 waits.
        for (int k = 0; k < 8; k++) begin rt[k] = 0; rd[k] = 8'h00; rg[k] = '0; end
        n_rec = 0;
        load(1, 3, 8'h41); load(2, 1, 8'h55);
        for (int t = 0; t < 80 && n_rec < 4; t++) begin
            cyc();
            if (tx_strobe) begin rt[n_rec] = t; rd[n_rec] = tx_data; rg[n_rec] = grant; n_rec++; end
        end
        check_eq("s2_count", 32'(n_rec), 32'd4);
        for (int k = 0; k < 3; k++) begin
            check_eq("s2_owner", rg[k], 4'b0010);
            check_eq("s2_word", rd[k], 8'h41 + 8'(k));
        end
        check_eq("s2_space1", 32'(rt[1] - rt[0]), 32'd5);
        check_eq("s2_space2", 32'(rt[2] - rt[1]), 32'd5);
        check_eq("s2_then_req2", rg[3], 4'b0100);
        check_eq("s2_req2_word", rd[3], 8'h55);
        wait_quiet("s2_quiet");

        // tx_busy held for 10 cycles in PUSH.
        tx_busy = 1'b1;
        load(3, 1, 8'h5A);
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (grant != '0) break;
        end
        check_eq("s3_grant", grant, 4'b1000);
        for (int t = 0; t < 10; t++) begin
            cyc();
            check_eq("s3_hold_strobe", tx_strobe, 1'b0);
            check_eq("s3_hold_ack", req_ack, 4'b0000);
        end
        tx_busy = 1'b0;
        cyc();
        check_eq("s3_release_strobe", tx_strobe, 1'b1);
        check_eq("s3_release_data", tx_data, 8'h5A);
        wait_quiet("s3_quiet");

        // Owner drops req mid-packet long enough to time out.
        load(0, 2, 8'h61); load(1, 1, 8'h62);
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (req_ack[0]) begin seen = 1'b1; break; end
        end
        check_eq("s4_first_ack", 32'(seen), 32'd1);
        hold[0] = 1'b1;
        n_abort = 0; g_at = 4'b1111; next_g = '0;
        for (int t = 0; t < 60; t++) begin
            cyc();
            if (abort) begin n_abort++; g_at = grant; end
            if (n_abort > 0 && grant != '0 && next_g == '0) next_g = grant;
        end
        hold[0] = 1'b0;
        check_eq("s4_abort_once", 32'(n_abort), 32'd1);
        check_eq("s4_grant_at_abort", g_at, 4'b0000);
        check_eq("s4_next_owner", next_g, 4'b0010);
        wait_quiet("s4_quiet");

        // Reset during SETTLE of word 2 of 3.
        load(2, 3, 8'h71);
        n_str = 0;
        for (int t = 0; t < 40 && n_str < 2; t++) begin
            cyc();
            if (tx_strobe) n_str++;
        end
        check_eq("s5_two_words", 32'(n_str), 32'd2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("s5_grant", grant, 4'b0000);
        check_eq("s5_active", active, 1'b0);
        check_eq("s5_strobe", tx_strobe, 1'b0);
        check_eq("s5_data", tx_data, 8'h00);
        n_str = 0;
        for (int t = 0; t < 30; t++) begin
            cyc();
            if (tx_strobe) n_str++;
        end
        check_eq("s5_no_more_strobes", 32'(n_str), 32'd0);

        // All four requesters continuously sending single-word packets.
        auto_mode = 1'b1;
        n_rec = 0; prevg = '0;
        for (int k = 0; k < 8; k++) rg[k] = '0;
        for (int t = 0; t < 120 && n_rec < 8; t++) begin
            cyc();
            if (grant != '0 && prevg == '0) begin rg[n_rec] = grant; n_rec++; end
            prevg = grant;
        end
        auto_mode = 1'b0;
        for (int k = 0; k < 8; k++) check_eq("s6_rotation", rg[k], 4'b0001 << (k % 4));
        wait_quiet("s6_quiet");

        // Random traffic with busy, drops and occasional reset.
        rand_mode = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            cyc();
            tx_busy = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 39) == 0) hold = 4'($urandom) & 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        rand_mode = 1'b0; hold = '0; tx_busy = 1'b0; rst = 1'b0;
        wait_quiet("rand_quiet");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
